board_link: RTL and testbench

Point-to-point message link between the two game boards over the 10-bit parallel `check_out` / `check_in` pins. It serialises game-level requests from `logic_ctl` into held pin states and filters and decodes the partner board's pin states into single-cycle message strobes for `logic_ctl` / `game_board`. It runs on the 75 MHz pixel clock domain and replaces the unused `check_in` / `check_out` tie-offs in `top_vga`.

---
 rtl/board_link.sv | 174 +++++++++++++++++
 tb/tb_board_link.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/board_link.sv
// Board-to-board message link: holds tx requests on check_out for a fixed window,
// and filters/decodes the partner's check_in pins into one-cycle rx strobes.
module board_link #(
    parameter int STABLE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 1024,
    parameter int GAP_CYCLES    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [1:0] tx_code,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [9:0] check_out,
    input  logic [9:0] check_in,
    output logic       rx_valid,
    output logic [1:0] rx_code,
    output logic [7:0] rx_data,
    output logic       link_err
);

    localparam int TX_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW     = $clog2(TX_MAX + 1);
    localparam int SW     = $clog2(STABLE_CYCLES + 1);

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TX_ONE    = TW'(1);
    localparam logic [SW-1:0] STAB_PRE  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ONE  = SW'(1);

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_DRIVE = 2'd1, TX_GAP = 2'd2} tx_state_t;
    typedef enum logic {RX_ARMED = 1'b0, RX_HELD = 1'b1} rx_state_t;

    tx_state_t     r_tx_state;
    logic [TW-1:0] r_tx_cnt;
    logic [9:0]    r_check_out;
    logic          r_tx_ready;

    logic [9:0]    r_sync1;
    logic [9:0]    r_s;
    logic [9:0]    r_s_prev;
    logic [SW-1:0] r_stab;

    rx_state_t     r_rx_state;
    logic          r_rx_valid;
    logic [1:0]    r_rx_code;
    logic [7:0]    r_rx_data;
    logic          r_link_err;

    logic          w_same;
    logic          w_stable;

    assign w_same   = (r_s == r_s_prev);
    assign w_stable = w_same && (r_stab == STAB_PRE);

    // Transmit FSM: drive the message, then idle the pins for a gap before re-arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_check_out <= 10'h000;
            r_tx_ready  <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid && (tx_code != 2'b00)) begin
                        r_tx_state  <= TX_DRIVE;
                        r_tx_cnt    <= '0;
                        r_check_out <= {tx_code, tx_data};
                        r_tx_ready  <= 1'b0;
                    end
                end
                TX_DRIVE: begin
                    if (r_tx_cnt == HOLD_LAST) begin
                        r_tx_state  <= TX_GAP;
                        r_tx_cnt    <= '0;
                        r_check_out <= 10'h000;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TX_ONE;
                    end
                end
                TX_GAP: begin
                    if (r_tx_cnt == GAP_LAST) begin
                        r_tx_state <= TX_IDLE;
                        r_tx_cnt   <= '0;
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TX_ONE;
                    end
                end
                default: begin
                    r_tx_state  <= TX_IDLE;
                    r_tx_cnt    <= '0;
                    r_check_out <= 10'h000;
                    r_tx_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus previous-sample register for change detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 10'h000;
            r_s      <= 10'h000;
            r_s_prev <= 10'h000;
        end else begin
            r_sync1  <= check_in;
            r_s      <= r_sync1;
            r_s_prev <= r_s;
        end
    end

    // Stability counter: restarts on any change, saturates so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stab <= '0;
        end else if (!w_same) begin
            r_stab <= '0;
        end else if (r_stab != STAB_MAX) begin
            r_stab <= r_stab + STAB_ONE;
        end else begin
            r_stab <= r_stab;
        end
    end

    // Receive decoder; code 00 means idle regardless of the data bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_ARMED;
            r_rx_valid <= 1'b0;
            r_rx_code  <= 2'b00;
            r_rx_data  <= 8'h00;
            r_link_err <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_stable) begin
                case (r_rx_state)
                    RX_ARMED: begin
                        if (r_s[9:8] != 2'b00) begin
                            r_rx_code  <= r_s[9:8];
                            r_rx_data  <= r_s[7:0];
                            r_rx_valid <= 1'b1;
                            r_rx_state <= RX_HELD;
                        end
                    end
                    RX_HELD: begin
                        if (r_s[9:8] == 2'b00) begin
                            r_rx_state <= RX_ARMED;
                        end else if (r_s != {r_rx_code, r_rx_data}) begin
                            r_link_err <= 1'b1;
                            r_rx_code  <= r_s[9:8];
                            r_rx_data  <= r_s[7:0];
                            r_rx_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_rx_state <= RX_ARMED;
                    end
                endcase
            end
        end
    end

    assign tx_ready  = r_tx_ready;
    assign check_out = r_check_out;
    assign rx_valid  = r_rx_valid;
    assign rx_code   = r_rx_code;
    assign rx_data   = r_rx_data;
    assign link_err  = r_link_err;

endmodule

// File: tb/tb_board_link.sv
// Directed bench for board_link with default parameters; expected values are hand-derived.
module tb_board_link;

    localparam int STABLE = 16;
    localparam int HOLD   = 1024;
    localparam int GAP    = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [1:0] tx_code = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic [9:0] check_out;
    logic [9:0] check_in = 10'h000;
    logic       rx_valid;
    logic [1:0] rx_code;
    logic [7:0] rx_data;
    logic       link_err;

    int n_total = 0;
    int n_pass  = 0;

    board_link #(.STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_code(tx_code), .tx_data(tx_data), .tx_ready(tx_ready),
        .check_out(check_out), .check_in(check_in),
        .rx_valid(rx_valid), .rx_code(rx_code), .rx_data(rx_data), .link_err(link_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Advance n cycles sampling at negedge; count rx_valid pulses and first pulse index (1-based).
    task automatic run_cycles(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                pulses++;
                if (first == 0) first = i + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int p, f, p2, f2;
        int drive_ok, gap_ok, ready_low;
        logic ready_back;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_check_out", 32'(check_out), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h1);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_code", 32'(rx_code), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_link_err", 32'(link_err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_tx_ready", 32'(tx_ready), 32'h1);

        // Illegal code 00 is ignored
        tx_valid = 1'b1; tx_code = 2'b00; tx_data = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        check("illegal_tx_ready", 32'(tx_ready), 32'h1);
        check("illegal_check_out", 32'(check_out), 32'h0);

        // Tx message 0x12A with a second request during DRIVE
        tx_valid = 1'b1; tx_code = 2'b01; tx_data = 8'h2A;
        @(negedge clk);
        tx_valid = 1'b0;
        drive_ok = 0; gap_ok = 0; ready_low = 0; ready_back = 1'b0;
        for (int k = 0; k <= HOLD + GAP; k++) begin
            if (k == 10) begin tx_valid = 1'b1; tx_code = 2'b11; tx_data = 8'h77; end
            if (k == 11) tx_valid = 1'b0;
            if (k < HOLD && check_out === 10'h12A) drive_ok++;
            if (k >= HOLD && k < HOLD + GAP && check_out === 10'h000) gap_ok++;
            if (k < HOLD + GAP && tx_ready === 1'b0) ready_low++;
            if (k == HOLD + GAP) ready_back = tx_ready;
            @(negedge clk);
        end
        check("tx_drive_cycles", 32'(drive_ok), 32'(HOLD));
        check("tx_gap_cycles", 32'(gap_ok), 32'(GAP));
        check("tx_ready_low_cycles", 32'(ready_low), 32'(HOLD + GAP));
        check("tx_ready_return", 32'(ready_back), 32'h1);

        // Rx accept of 0x305
        check_in = 10'h305;
        run_cycles(5000, p, f);
        check("rx_accept_pulses", 32'(p), 32'h1);
        check("rx_accept_latency", 32'(f), 32'(STABLE + 3));
        check("rx_accept_code", 32'(rx_code), 32'h3);
        check("rx_accept_data", 32'(rx_data), 32'h05);
        check("rx_accept_err", 32'(link_err), 32'h0);

        // Glitch shorter than the filter, then idle
        check_in = 10'h1FF;
        run_cycles(10, p, f);
        check_in = 10'h000;
        run_cycles(60, p2, f2);
        check("glitch_pulses", 32'(p + p2), 32'h0);
        check("glitch_err", 32'(link_err), 32'h0);
        check("glitch_code_held", 32'({rx_code, rx_data}), 32'h305);

        // Protocol error: 0x101 then 0x203 with no idle
        check_in = 10'h101;
        run_cycles(100, p, f);
        check("err_first_pulse", 32'(p), 32'h1);
        check("err_first_no_err", 32'(link_err), 32'h0);
        check_in = 10'h203;
        run_cycles(100, p2, f2);
        check("err_second_pulse", 32'(p2), 32'h1);
        check("err_set", 32'(link_err), 32'h1);
        check("err_latched", 32'({rx_code, rx_data}), 32'h203);
        check_in = 10'h000;
        run_cycles(200, p, f);
        check("err_sticky", 32'(link_err), 32'h1);
        do_reset();
        check("err_cleared_by_reset", 32'(link_err), 32'h0);

        // Re-arm through idle
        check_in = 10'h101;
        run_cycles(60, p, f);
        check_in = 10'h000;
        run_cycles(32, p2, f2);
        p = p + p2;
        check_in = 10'h101;
        run_cycles(60, p2, f2);
        check("rearm_pulses", 32'(p + p2), 32'h2);
        check("rearm_no_err", 32'(link_err), 32'h0);

        // Async reset mid-DRIVE
        tx_valid = 1'b1; tx_code = 2'b10; tx_data = 8'h11;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_pre_drive", 32'(check_out), 32'h211);
        #2 rst = 1'b0;
        #1;
        check("abort_check_out", 32'(check_out), 32'h0);
        check("abort_tx_ready", 32'(tx_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle_after", 32'(check_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
